// File: rtl/rf_arb_pkg.sv
// Shared constants, state type and round-robin helper for the register-file port arbiter.
package rf_arb_pkg;

  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NREGS    = 16;
  localparam int unsigned NREQ_MAX = 4;
  localparam int unsigned IDX_W    = 2;

  typedef enum logic [0:0] {
    ST_INIT,
    ST_RUN
  } arb_state_t;

  // Index following idx in a ring of n requesters.
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx,
                                               input int unsigned n);
    int unsigned nxt;
    nxt = {30'd0, idx} + 32'd1;
    if (nxt >= n) nxt = 0;
    return nxt[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: priority starts at the pointer, pointer moves past the winner on a grant.
// gnt_idx/found report the would-be winner even when en is low.
module rr_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             found
);

  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    cand;
  logic [NREQ_MAX-1:0] req_pad;
  logic [NREQ_MAX-1:0] gnt_pad;

  always_comb begin
    req_pad          = '0;
    req_pad[N-1:0]   = req;
    found            = 1'b0;
    gnt_idx          = '0;
    cand             = ptr_q;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && req_pad[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
      cand = rr_next(cand, N);
    end
    gnt_pad = '0;
    if (found && en) gnt_pad[gnt_idx] = 1'b1;
    gnt   = gnt_pad[N-1:0];
    ptr_d = (found && en) ? rr_next(gnt_idx, N) : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rf_port_arbiter.sv
// Shares the register file's write port and read port 1 between NREQ requesters, with an
// optional zeroing sweep after reset.
module rf_port_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned NREQ           = 2,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_write,
  input  logic [ADDR_W*NREQ-1:0] req_addr,
  input  logic [DATA_W*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   busy,
  output logic [ADDR_W-1:0]      rf_a1,
  output logic [ADDR_W-1:0]      rf_a3,
  output logic                   rf_we3,
  output logic [DATA_W-1:0]      rf_wd3,
  input  logic [DATA_W-1:0]      rf_rd1
);

  arb_state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] rf_a1_q;
  logic [NREQ-1:0]   rsp_valid_q;

  logic [NREQ_MAX*ADDR_W-1:0] addr_pad;
  logic [NREQ_MAX*DATA_W-1:0] wdata_pad;

  logic              run, sweep, hazard;
  logic [NREQ-1:0]   w_gnt, r_gnt;
  logic [IDX_W-1:0]  w_idx, r_idx;
  logic              w_found, r_found;
  logic [ADDR_W-1:0] w_addr, r_addr;
  logic [DATA_W-1:0] w_data;

  // Outputs are gated by rst_n so nothing reaches the register file during a reset cycle.
  assign run   = (state_q == ST_RUN) && rst_n;
  assign sweep = (state_q == ST_INIT) && rst_n;

  always_comb begin
    addr_pad                    = '0;
    addr_pad[ADDR_W*NREQ-1:0]   = req_addr;
    wdata_pad                   = '0;
    wdata_pad[DATA_W*NREQ-1:0]  = req_wdata;
  end

  assign w_addr = addr_pad[ADDR_W*w_idx +: ADDR_W];
  assign w_data = wdata_pad[DATA_W*w_idx +: DATA_W];
  assign r_addr = addr_pad[ADDR_W*r_idx +: ADDR_W];

  // Same-address read alongside a write would see stale data; hold the read a cycle.
  assign hazard = w_found && r_found && (w_addr == r_addr);

  rr_arbiter #(
    .N (NREQ)
  ) u_wr_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid & req_write),
    .en      (run),
    .gnt     (w_gnt),
    .gnt_idx (w_idx),
    .found   (w_found)
  );

  rr_arbiter #(
    .N (NREQ)
  ) u_rd_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid & ~req_write),
    .en      (run && !hazard),
    .gnt     (r_gnt),
    .gnt_idx (r_idx),
    .found   (r_found)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
      cnt_q       <= '0;
      rf_a1_q     <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rf_a1_q     <= rf_a1;
      rsp_valid_q <= r_gnt;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(NREGS - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_comb begin
    rf_we3 = 1'b0;
    rf_a3  = '0;
    rf_wd3 = '0;
    rf_a1  = rst_n ? rf_a1_q : '0;
    if (sweep) begin
      rf_we3 = 1'b1;
      rf_a3  = cnt_q;
    end else if (|w_gnt) begin
      rf_we3 = 1'b1;
      rf_a3  = w_addr;
      rf_wd3 = w_data;
    end
    if (|r_gnt) rf_a1 = r_addr;
    req_ready = w_gnt | r_gnt;
    rsp_valid = rsp_valid_q & {NREQ{rst_n}};
    rsp_rdata = rf_rd1;
    busy      = (state_q == ST_INIT);
  end

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Random and directed stimulus against a behavioural model of arbitration and register file.
module tb_rf_port_arbiter;

  localparam int NREQ = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_write = '0;
  logic [4*NREQ-1:0]    req_addr = '0;
  logic [32*NREQ-1:0]   req_wdata = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      rsp_valid;
  logic [31:0]          rsp_rdata;
  logic                 busy;
  logic [3:0]           rf_a1, rf_a3;
  logic                 rf_we3;
  logic [31:0]          rf_wd3;
  logic [31:0]          rf_rd1 = '0;

  logic [31:0] rf [16];
  logic        preload = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  int          m_wptr, m_rptr;
  logic [31:0] m_rf [16];
  logic [3:0]  m_a1;
  logic [NREQ-1:0] m_rsp_v;
  logic [31:0] m_rsp_d;

  rf_port_arbiter #(
    .NREQ           (NREQ),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .rf_a1     (rf_a1),
    .rf_a3     (rf_a3),
    .rf_we3    (rf_we3),
    .rf_wd3    (rf_wd3),
    .rf_rd1    (rf_rd1)
  );

  always #5 clk = ~clk;

  // Register file: synchronous write, registered read-before-write on port 1
  always @(posedge clk) begin
    if (preload) rf[5] <= 32'h5;
    else if (rf_we3) rf[rf_a3] <= rf_wd3;
    rf_rd1 <= rf[rf_a1];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] c, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (ptr + k) % NREQ;
      if (c[i]) return i;
    end
    return -1;
  endfunction

  task automatic drive_rand();
    logic [31:0] t;
    t = $urandom;
    req_valid = t[NREQ-1:0];
    t = $urandom;
    req_write = t[NREQ-1:0];
    for (int i = 0; i < NREQ; i++) begin
      req_addr[4*i +: 4]   = 4'($urandom_range(0, 3));
      req_wdata[32*i +: 32] = $urandom;
    end
  endtask

  task automatic step(input logic [NREQ-1:0] v, input logic [NREQ-1:0] w,
                      input logic [4*NREQ-1:0] a, input logic [32*NREQ-1:0] d);
    int wi, ri;
    logic [NREQ-1:0] e_rdy;
    @(negedge clk);
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    #1;
    wi = pick(v & w, m_wptr);
    ri = pick(v & ~w, m_rptr);
    if (wi >= 0 && ri >= 0 && a[4*ri +: 4] == a[4*wi +: 4]) ri = -1;
    e_rdy = '0;
    if (wi >= 0) e_rdy[wi] = 1'b1;
    if (ri >= 0) e_rdy[ri] = 1'b1;
    check_eq("req_ready", 64'(req_ready), 64'(e_rdy));
    check_eq("rsp_valid", 64'(rsp_valid), 64'(m_rsp_v));
    if (m_rsp_v != '0) check_eq("rsp_rdata", 64'(rsp_rdata), 64'(m_rsp_d));
    check_eq("busy", 64'(busy), 64'(0));
    check_eq("rf_we3", 64'(rf_we3), 64'(wi >= 0));
    if (wi >= 0) begin
      check_eq("rf_a3", 64'(rf_a3), 64'(a[4*wi +: 4]));
      check_eq("rf_wd3", 64'(rf_wd3), 64'(d[32*wi +: 32]));
    end
    if (ri >= 0) m_a1 = a[4*ri +: 4];
    check_eq("rf_a1", 64'(rf_a1), 64'(m_a1));
    m_rsp_v = '0;
    if (ri >= 0) begin
      m_rsp_v[ri] = 1'b1;
      m_rsp_d     = m_rf[m_a1];
      m_rptr      = (ri + 1) % NREQ;
    end
    if (wi >= 0) begin
      m_rf[a[4*wi +: 4]] = d[32*wi +: 32];
      m_wptr = (wi + 1) % NREQ;
    end
  endtask

  task automatic idle();
    step('0, '0, '0, '0);
  endtask

  // Holds rst_n low across one rising edge; checks the outputs are quiet meanwhile.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_rand();
    #1;
    check_eq("rst_ready", 64'(req_ready), 64'(0));
    check_eq("rst_we3", 64'(rf_we3), 64'(0));
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    m_wptr = 0;
    m_rptr = 0;
    m_a1   = '0;
    m_rsp_v = '0;
  endtask

  task automatic sweep_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive_rand();
      #1;
      check_eq("sweep_busy", 64'(busy), 64'(1));
      check_eq("sweep_we3", 64'(rf_we3), 64'(1));
      check_eq("sweep_a3", 64'(rf_a3), 64'(i % 16));
      check_eq("sweep_wd3", 64'(rf_wd3), 64'(0));
      check_eq("sweep_ready", 64'(req_ready), 64'(0));
      check_eq("sweep_rsp_valid", 64'(rsp_valid), 64'(0));
      m_rf[i] = '0;
    end
  endtask

  initial begin
    logic [NREQ-1:0]    v, w;
    logic [4*NREQ-1:0]  a;
    logic [32*NREQ-1:0] d;
    logic [31:0]        t;

    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    @(negedge clk);
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;

    // Sweep clears the preloaded register
    do_reset();
    sweep_check(16);
    step(2'b01, 2'b00, {4'h0, 4'h5}, '0);
    idle();

    // Round-robin reads
    repeat (4) step(2'b11, 2'b00, {4'h7, 4'h3}, '0);
    idle();

    // Parallel write and read
    step(2'b11, 2'b01, {4'h4, 4'h2}, {32'h0, 32'hDEADBEEF});
    idle();

    // Same-address hazard: read held one cycle, then returns the new data
    step(2'b11, 2'b01, {4'h9, 4'h9}, {32'h0, 32'h12345678});
    step(2'b10, 2'b00, {4'h9, 4'h0}, '0);
    idle();

    // Write fairness on one register, then read it back
    repeat (5) step(2'b11, 2'b11, {4'h1, 4'h1}, {32'hBBBB0000, 32'hAAAA0000});
    step(2'b01, 2'b00, {4'h0, 4'h1}, '0);
    idle();

    // Randomised traffic
    for (int n = 0; n < 300; n++) begin
      t = $urandom;
      v = t[NREQ-1:0];
      t = $urandom;
      w = t[NREQ-1:0];
      for (int i = 0; i < NREQ; i++) begin
        a[4*i +: 4]   = (n % 2 == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
        d[32*i +: 32] = $urandom;
      end
      step(v, w, a, d);
    end

    // Reset on sweep cycle 8 restarts the sweep from register 0
    do_reset();
    sweep_check(8);
    do_reset();
    sweep_check(16);
    for (int n = 0; n < 20; n++) begin
      t = $urandom;
      v = t[NREQ-1:0];
      t = $urandom;
      w = t[NREQ-1:0];
      for (int i = 0; i < NREQ; i++) begin
        a[4*i +: 4]   = 4'($urandom_range(0, 3));
        d[32*i +: 32] = $urandom;
      end
      step(v, w, a, d);
    end

    // Reset the cycle after a read grant drops the response
    step(2'b01, 2'b00, {4'h0, 4'h3}, '0);
    do_reset();
    sweep_check(16);
    repeat (10) begin
      t = $urandom;
      v = t[NREQ-1:0];
      t = $urandom;
      w = t[NREQ-1:0];
      for (int i = 0; i < NREQ; i++) begin
        a[4*i +: 4]   = 4'($urandom_range(0, 3));
        d[32*i +: 32] = $urandom;
      end
      step(v, w, a, d);
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rf_port_arbiter.md
Name: rf_port_arbiter

Overview:
- Shares the 16x32 register file's single write port (A3/WE3/WD3) and read port 1 (A1/RD1) between NREQ requesters, for example the core pipeline and a debug/scan master.
- Reads and writes are arbitrated independently, each round-robin, so one read and one write can be granted in the same cycle.
- After reset, a sweep state machine can clear all 16 registers before any requester is served.
- The block sits directly between the requesters and the register file.

Parameters:
- NREQ, 2, number of requesters (2..4).
- CLEAR_ON_RESET, 1, 1 = run the 16-cycle zeroing sweep after reset; 0 = go straight to ST_RUN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_write  in  NREQ  1 = write, 0 = read.
- req_addr  in  4*NREQ  register index; requester i uses bits [4i+3:4i].
- req_wdata  in  32*NREQ  write data, same packing.
- req_ready  out  NREQ  grant; a transfer occurs when req_valid[i] and req_ready[i] are both 1.
- rsp_valid  out  NREQ  one-hot read-data valid, one cycle after the read grant.
- rsp_rdata  out  32  read data, broadcast to all requesters.
- busy  out  1  high while in ST_INIT.
- rf_a1  out  4  register-file read address 1.
- rf_a3  out  4  register-file write address.
- rf_we3  out  1  register-file write enable.
- rf_wd3  out  32  register-file write data.
- rf_rd1  in  32  register-file read data; registered, valid on the edge after rf_a1 is sampled.

Behaviour:
- Reset (rst_n low at a clk edge):
  - req_ready = 0, rsp_valid = 0, rf_we3 = 0, rf_a1 = 0, rf_a3 = 0, rf_wd3 = 0, sweep counter = 0.
  - Both round-robin pointers go to requester 0.
  - State becomes ST_INIT if CLEAR_ON_RESET, else ST_RUN.
  - Reset asserted mid-sweep or mid-transaction aborts it. Any outstanding rsp_valid is dropped.
- ST_INIT:
  - busy = 1, req_ready = 0.
  - rf_we3 = 1, rf_a3 = counter, rf_wd3 = 0. The counter increments 0..15.
  - When a write with counter = 15 completes, go to ST_RUN.
  - busy deasserts on the cycle the block enters ST_RUN.
  - Total: 16 write cycles.
- ST_RUN, arbitration (all combinational from inputs and pointers):
  - Write candidates: valid & write. Read candidates: valid & ~write.
  - Each class has its own round-robin pointer. Priority starts at the pointer and wraps modulo NREQ.
  - A pointer advances to (granted index + 1) mod NREQ only on a grant. No grant leaves it unchanged.
  - At most one write grant and one read grant per cycle. They necessarily go to different requesters.
- ST_RUN, driving the register file:
  - Write grant: rf_we3 = 1, rf_a3/rf_wd3 = the granted requester's fields. The register file updates at that edge.
  - Read grant: rf_a1 = the granted requester's address. The register file captures RD1 at that edge.
  - rsp_valid[i] = 1 and rsp_rdata = rf_rd1 in the following cycle. Read latency is exactly 1 cycle and the response is never stalled; requesters must accept it.
  - With no read grant, rf_a1 holds its last value.
- Read/write same-address hazard:
  - The register file returns the old value when RD1 is sampled at the same edge as the write.
  - Therefore, if the winning read address equals the granted write address in the same cycle, the read grant is suppressed for that cycle (write-first).
  - The read pointer does not advance. The read is re-arbitrated next cycle and returns the new data.
- A write with req_addr = X followed by a read of X in the next cycle returns the new value. No hazard, because the write completed at the earlier edge.
- Requests held valid while not ready must keep their fields stable. The arbiter must not depend on that for correctness.
- Unused requester slots (index >= NREQ) do not exist; no X-propagation on req vectors.

Decomposition:
- Package rf_arb_pkg:
  - ADDR_W = 4, DATA_W = 32, NREGS = 16.
  - Enum arb_state_t {ST_INIT, ST_RUN}.
  - A function for the next round-robin index.
- Sub-module rr_arbiter (parameter N), instantiated twice, once for reads and once for writes:
  - Inputs: req vector, enable.
  - Outputs: one-hot grant and grant index.
  - Pointer register with synchronous active-low reset.

Test Plan:
- Sweep: reset with CLEAR_ON_RESET = 1, after pre-loading rf[5] = 0x5 → busy high for 16 cycles, rf_we3 = 1 with rf_a3 = 0..15 and rf_wd3 = 0, req_ready = 0; afterwards a read of reg 5 returns 0x0.
- Round-robin reads: both requesters hold reads (r0 addr 3, r1 addr 7) for 4 cycles → grants alternate r0, r1, r0, r1; each rsp_valid appears 1 cycle after its grant with 0x0 (after the sweep).
- Parallel grants: r0 writes reg 2 = 0xDEADBEEF while r1 reads reg 4 in the same cycle → both ready; rf_we3 = 1, rf_a1 = 4; rsp_valid = 2'b10 next cycle.
- Hazard: r0 writes reg 9 = 0x12345678 while r1 reads reg 9 in the same cycle → r1 not ready that cycle; granted next cycle; rsp_rdata = 0x12345678.
- Write fairness: both requesters write continuously (r0 → reg 1, r1 → reg 1) → alternating grants, and the final value equals the data of the last granted requester.
- Reset mid-operation: assert rst_n = 0 on sweep cycle 8 → the sweep restarts from 0; assert rst_n = 0 the cycle after a read grant → no rsp_valid is emitted.
